// File: rtl/riscv_aes_pkg.sv
// Shared constants and state encoding for the AES sequencer.
package riscv_aes_pkg;

  localparam int AES_BLOCK_WIDTH = 128;
  localparam int AES_NUM_WORDS   = 4;

  // Byte enables for a full-word write-back.
  localparam logic [3:0] AES_WB_BE = 4'hF;

  // state     | meaning
  // IDLE      | waiting for a start command, operands captured on start
  // START     | one-cycle start pulse to the AES core
  // WAIT_CORE | waiting for the core result pulse
  // WB_REQ    | memory request for the current word (top: whole write-back loop)
  // WB_RESP   | request granted, waiting for the write response
  // DONE      | one-cycle completion pulse
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_CORE = 3'd2,
    WB_REQ    = 3'd3,
    WB_RESP   = 3'd4,
    DONE      = 3'd5
  } aes_ctrl_state_e;

endpackage

// File: rtl/riscv_aes_wb_seq.sv
// Write-back loop: stores a result block word by word to memory,
// keeping exactly one transaction outstanding.
module riscv_aes_wb_seq
  import riscv_aes_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            go_i,
  input  logic [31:0]                     base_i,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] result_i,
  output logic                            data_req_o,
  input  logic                            data_gnt_i,
  input  logic                            data_rvalid_i,
  output logic [31:0]                     data_addr_o,
  output logic [DATA_WIDTH-1:0]           data_wdata_o,
  output logic                            data_we_o,
  output logic [3:0]                      data_be_o,
  output logic                            finished_o
);

  localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);
  localparam logic [31:0] WORD_BYTES = 32'(DATA_WIDTH / 8);

  aes_ctrl_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and word counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request/response handshake per word; a response seen in the request
  // cycle is ignored so only the grant advances the loop there.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_req_o = 1'b0;
    finished_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (go_i) begin
          cnt_d   = '0;
          state_d = WB_REQ;
        end
      end
      WB_REQ: begin
        data_req_o = 1'b1;
        if (data_gnt_i) begin
          state_d = WB_RESP;
        end
      end
      WB_RESP: begin
        if (data_rvalid_i) begin
          if (cnt_q == LAST_WORD) begin
            finished_o = 1'b1;
            state_d    = IDLE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = WB_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus fields are driven only while a request is up; address wraps mod 2^32.
  always_comb begin
    data_addr_o  = '0;
    data_wdata_o = '0;
    data_we_o    = 1'b0;
    data_be_o    = '0;
    if (data_req_o) begin
      data_addr_o  = base_i + (32'(cnt_q) * WORD_BYTES);
      data_wdata_o = result_i[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH];
      data_we_o    = 1'b1;
      data_be_o    = AES_WB_BE;
    end
  end

endmodule

// File: rtl/riscv_aes_ctrl.sv
// AES command sequencer: captures operands, starts the core, waits for the
// result and hands it to the write-back loop, then signals completion.
module riscv_aes_ctrl
  import riscv_aes_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = AES_NUM_WORDS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            aes_start_i,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] data_i,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] key_i,
  input  logic [31:0]                     wb_addr_i,
  output logic                            core_start_o,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] core_data_o,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] core_key_o,
  input  logic                            core_done_i,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] core_result_i,
  output logic                            data_req_o,
  input  logic                            data_gnt_i,
  input  logic                            data_rvalid_i,
  output logic [31:0]                     data_addr_o,
  output logic [DATA_WIDTH-1:0]           data_wdata_o,
  output logic                            data_we_o,
  output logic [3:0]                      data_be_o,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam int BLK_W = NUM_WORDS * DATA_WIDTH;

  aes_ctrl_state_e   state_q, state_d;
  logic [BLK_W-1:0]  data_q, data_d;
  logic [BLK_W-1:0]  key_q, key_d;
  logic [BLK_W-1:0]  result_q, result_d;
  logic [31:0]       base_q, base_d;
  logic              wb_go;
  logic              wb_finished;

  // Controller registers with synchronous reset; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      key_q    <= '0;
      result_q <= '0;
      base_q   <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      key_q    <= key_d;
      result_q <= result_d;
      base_q   <= base_d;
    end
  end

  // Next-state logic; the write-back loop is a single WB_REQ state here.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    key_d    = key_q;
    result_d = result_q;
    base_d   = base_q;
    wb_go    = 1'b0;
    case (state_q)
      IDLE: begin
        if (aes_start_i) begin
          data_d  = data_i;
          key_d   = key_i;
          base_d  = wb_addr_i & 32'hFFFF_FFFC;
          state_d = START;
        end
      end
      START: state_d = WAIT_CORE;
      WAIT_CORE: begin
        if (core_done_i) begin
          result_d = core_result_i;
          wb_go    = 1'b1;
          state_d  = WB_REQ;
        end
      end
      WB_REQ: begin
        if (wb_finished) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status and core-side outputs decoded from state and latched operands.
  always_comb begin
    core_start_o = (state_q == START);
    done_o       = (state_q == DONE);
    busy_o       = (state_q != IDLE);
    core_data_o  = data_q;
    core_key_o   = key_q;
  end

  riscv_aes_wb_seq #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_WORDS (NUM_WORDS)
  ) u_wb_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .go_i         (wb_go),
    .base_i       (base_q),
    .result_i     (result_q),
    .data_req_o   (data_req_o),
    .data_gnt_i   (data_gnt_i),
    .data_rvalid_i(data_rvalid_i),
    .data_addr_o  (data_addr_o),
    .data_wdata_o (data_wdata_o),
    .data_we_o    (data_we_o),
    .data_be_o    (data_be_o),
    .finished_o   (wb_finished)
  );

endmodule

// File: doc/riscv_aes_ctrl.md
Name: riscv_aes_ctrl

Overview:
Sequencer between the AES operand/key register file and the AES core, and the data-memory port.
- On a start command it launches one AES block operation.
- When the core finishes, it writes the 128-bit result as four 32-bit words to memory starting at the write-back address.
- It raises busy_o so the core pipeline can stall further AES commands, and pulses done_o on completion.

Parameters:
DATA_WIDTH, 32, width of one memory word and one register-file word
NUM_WORDS, 4, number of words per AES block (block width = NUM_WORDS*DATA_WIDTH)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
aes_start_i  in  1  start command from register file
data_i  in  128  plaintext; word k = bits [32k+31:32k]
key_i  in  128  key, same packing as data_i
wb_addr_i  in  32  write-back base byte address
core_start_o  out  1  one-cycle start pulse to AES core
core_data_o  out  128  latched plaintext to core
core_key_o  out  128  latched key to core
core_done_i  in  1  one-cycle result-valid pulse from core
core_result_i  in  128  ciphertext, valid with core_done_i
data_req_o  out  1  memory request
data_gnt_i  in  1  memory grant
data_rvalid_i  in  1  memory write response
data_addr_o  out  32  word-aligned byte address
data_wdata_o  out  32  write data
data_we_o  out  1  constant 1 while data_req_o is high, else 0
data_be_o  out  4  4'hF while data_req_o is high, else 0
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset (synchronous, rst_n=0 at a clk edge):
  - FSM goes to IDLE; all registers and outputs clear to 0.
  - Reset mid-operation aborts immediately: the request drops and no further write occurs.
- FSM states: IDLE, START, WAIT_CORE, WB_REQ, WB_RESP, DONE.
- IDLE:
  - If aes_start_i=1, latch data_i, key_i and wb_addr_i (with [1:0] forced to 0), clear word counter cnt, then go to START.
  - aes_start_i in any other state is ignored; nothing is queued.
- START: core_start_o=1 for exactly one cycle, then go to WAIT_CORE.
  - Start latency is 1 cycle: aes_start_i sampled at edge T gives core_start_o high during cycle T+1.
- core_data_o and core_key_o come directly from the latched registers and stay stable from START until the next IDLE capture.
- WAIT_CORE:
  - On core_done_i=1, latch core_result_i and go to WB_REQ.
  - There is no timeout; a core_done_i pulse in any other state is ignored.
- WB_REQ: drive the memory request until granted.
  - data_req_o=1, data_addr_o = base + 4*cnt (32-bit, wraps modulo 2^32), data_wdata_o = result word cnt.
  - Address and data hold stable until the cycle with data_gnt_i=1, then go to WB_RESP.
- WB_RESP: request deasserted; only one transaction is outstanding.
  - On data_rvalid_i=1: if cnt=NUM_WORDS-1, go to DONE; else cnt+1 and go to WB_REQ.
  - data_rvalid_i in any state other than WB_RESP is ignored.
- DONE: done_o=1 for one cycle, then go to IDLE. busy_o falls in the same cycle the FSM enters IDLE.
- Minimum total: 1 (START) + core latency + 4 × (grant cycle + response cycle) + 1 (DONE).
- Simultaneous events:
  - data_gnt_i and data_rvalid_i in the same WB_REQ cycle: only the grant is acted on, so rvalid must not arrive before the cycle after the grant.
  - aes_start_i in the DONE cycle is ignored.

Decomposition:
- Package riscv_aes_pkg holds:
  - AES_BLOCK_WIDTH=128 and AES_NUM_WORDS=4;
  - aes_ctrl_state_e enum (IDLE..DONE, 3-bit);
  - AES_WB_BE=4'hF.
- One natural sub-module, riscv_aes_wb_seq, covers the WB_REQ/WB_RESP word loop.
  - Inputs: base, 128-bit result, go pulse.
  - Outputs: the bus signals and a finished pulse.
  - The top FSM treats it as a single state.

Test Plan:
- Basic operation:
  - Stimulus: data_i=128'h00112233_44556677_8899AABB_CCDDEEFF, wb_addr_i=32'h1000, core done 10 cycles after start with result 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A; zero-wait gnt, rvalid the next cycle.
  - Response: writes in order 0x1000=70B4C55A, 0x1004=D8CDB780, 0x1008=6A7B0430, 0x100C=69C4E0D8; one done_o pulse; busy_o high for exactly the whole operation.
- Grant stall: gnt held low 3 cycles on word 2 -> data_req_o, data_addr_o=0x1008 and data_wdata_o stay constant for 4 cycles; write order unchanged.
- Wrap and alignment: wb_addr_i=32'hFFFF_FFFB -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Ignored starts: aes_start_i pulsed during WAIT_CORE and during WB_RESP -> exactly one core_start_o and 4 writes; a second start in IDLE afterwards runs normally.
- Reset mid-write: rst_n=0 for one edge while in WB_RESP of word 1 -> next cycle data_req_o=0, busy_o=0, done_o=0; a late rvalid is ignored and no further writes occur.
- Stale events: core_done_i pulse in IDLE and data_rvalid_i in WAIT_CORE -> no state change and no outputs toggle.
